// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the pipeline (fetch + data side), the arbiter and the memory.
// Handshake: a requester raises *_req with stable address/data and holds them while *_wait=1;
// *_valid pulses one cycle when its access finishes. Memory side: mem_req holds until mem_ack=1.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_wait;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_wait;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    output if_rdata, if_valid, if_wait, d_rdata, d_valid, d_wait,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_valid, if_wait, d_rdata, d_valid, d_wait,
           mem_req, mem_we, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between instruction fetch and data access.
// Data side wins ties; all memory-side outputs are registered; a watchdog flags stuck accesses.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  // State register (together with the registered outputs it produces)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_valid_q <= if_valid_d;
      d_valid_q  <= d_valid_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // A side whose valid is pulsing still shows its old address, so it is not granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.d_req && !d_valid_q)
          state_d = DATA;
        else if (bus.if_req && !if_valid_q)
          state_d = FETCH;
      end
      FETCH, DATA: begin
        if (bus.mem_ack)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_valid_d = 1'b0;
    d_valid_d  = 1'b0;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (state_q == IDLE && state_d == DATA) begin
      req_d   = 1'b1;
      we_d    = bus.d_we;
      addr_d  = bus.d_addr;
      wdata_d = bus.d_wdata;
      cnt_d   = '0;
    end else if (state_q == IDLE && state_d == FETCH) begin
      req_d  = 1'b1;
      we_d   = 1'b0;
      addr_d = bus.if_addr;
      cnt_d  = '0;
    end else if (state_q != IDLE) begin
      if (bus.mem_ack) begin
        req_d = 1'b0;
        we_d  = 1'b0;
        if (state_q == FETCH) begin
          if_valid_d = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end else begin
          d_valid_d = 1'b1;
          if (!we_q)
            d_rdata_d = bus.mem_rdata;
        end
      end else if (req_q) begin
        // Counter saturates at the limit; the access itself keeps waiting.
        if (cnt_q != TIMEOUT_C)
          cnt_d = cnt_q + 8'd1;
        if (cnt_q == TIMEOUT_C - 8'd1)
          err_d = 1'b1;
      end
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.err       = err_q;
  assign bus.if_wait   = bus.if_req & ~if_valid_q;
  assign bus.d_wait    = bus.d_req & ~d_valid_q;
  assign fsm_state     = state_q;

endmodule
